fetch: RTL and testbench

- Instruction-fetch stage. It is the producer side of the decode stage's `enable`/`pc`/`command` input interface.
- On a start pulse it reads one 32-bit instruction word from the synchronous instruction BRAM at the given byte PC.
- It then presents `pc_out`/`command` to decode with a one-cycle `done` pulse.
- It sits between the PC-select logic (exec/branch result) and decode.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_stats.sv | 36 +++
 rtl/fetch.sv | 153 +++++++++++++++
 tb/tb_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding, instruction width, nop word.
// Imported by the fetch stage and its optional statistics block.
package core_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_WAIT = 2'd2;
  localparam fetch_state_t S_RESP = 2'd3;

endpackage

// File: rtl/fetch_stats.sv
// Fetch statistics: counts good done pulses and busy cycles (wrap at 2^32).
// In: clk, rstn, done, fault, busy. Out: stat_fetches, stat_stall_cycles.
module fetch_stats (
  input  logic        clk,
  input  logic        rstn,
  input  logic        done,
  input  logic        fault,
  input  logic        busy,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_stall_cycles
);

  logic [31:0] fetches_q, fetches_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    fetches_d = fetches_q;
    stalls_d  = stalls_q;
    if (done && !fault) fetches_d = fetches_q + 32'd1;
    if (busy)           stalls_d  = stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetches_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      fetches_q <= fetches_d;
      stalls_q  <= stalls_d;
    end
  end

  assign stat_fetches      = fetches_q;
  assign stat_stall_cycles = stalls_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: one BRAM read per start pulse, done pulse to decode.
// In: clk, rstn, enable, pc_in, flush, imem_rdata. Out: done, pc_out, command,
// fault, busy, imem_en, imem_addr; stat_* when FETCH_STATS_EN is defined.
module fetch
  import core_pkg::*;
#(
  parameter int          ADDR_W      = 15,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  output logic              done,
  output logic [31:0]       pc_out,
  output logic [31:0]       command,
  output logic              fault,
  output logic              busy,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetches,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int CNT_W = 3;

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              bad_q, bad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       pco_q, pco_d;
  logic              pc_bad;

  assign pc_bad = (pc_in[1:0] != 2'b00) ||
                  ((pc_in >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    pco_d   = pco_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !flush) begin
          pc_d = pc_in;
          if (pc_bad) begin
            bad_d   = 1'b1;
            cmd_d   = NOP_WORD;
            state_d = S_RESP;
          end else begin
            en_d    = 1'b1;
            addr_d  = pc_in[ADDR_W+1:2];
            cnt_d   = CNT_W'(MEM_LATENCY);
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          cmd_d   = imem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        bad_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are set on the edge entering RESP so done lines up with data.
    done_d  = (state_d == S_RESP);
    fault_d = done_d && bad_d;
    if (done_d) pco_d = pc_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= NOP_WORD;
      pco_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      pco_q   <= pco_d;
    end
  end

  assign done      = done_q;
  assign fault     = fault_q;
  assign busy      = busy_q;
  assign imem_en   = en_q;
  assign imem_addr = addr_q;
  assign command   = cmd_q;
  assign pc_out    = pco_q;

`ifdef FETCH_STATS_EN
  fetch_stats u_stats (
    .clk               (clk),
    .rstn              (rstn),
    .done              (done_q),
    .fault             (fault_q),
    .busy              (busy_q),
    .stat_fetches      (stat_fetches),
    .stat_stall_cycles (stat_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: two instances (latency 1 and 3) on shared stimulus,
// BRAM models, scoreboard queues and a negedge monitor.
module tb_fetch;

  localparam int          AW  = 15;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = 32'h0;

  logic          done1, fault1, busy1, en1;
  logic          done3, fault3, busy3, en3;
  logic [31:0]   pco1, cmd1, pco3, cmd3;
  logic [AW-1:0] addr1, addr3;
  logic [31:0]   rd1 = 32'h0;
  logic [31:0]   rd3 = 32'h0;
`ifdef FETCH_STATS_EN
  logic [31:0]   sf1, ss1, sf3, ss3;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  fetch #(.ADDR_W(AW), .MEM_LATENCY(1), .RESET_PC(RPC)) u_f1 (
    .clk(clk), .rstn(rstn), .enable(enable), .pc_in(pc_in),
    .flush(flush), .done(done1), .pc_out(pco1), .command(cmd1),
    .fault(fault1), .busy(busy1), .imem_en(en1), .imem_addr(addr1),
    .imem_rdata(rd1)
`ifdef FETCH_STATS_EN
    , .stat_fetches(sf1), .stat_stall_cycles(ss1)
`endif
  );

  fetch #(.ADDR_W(AW), .MEM_LATENCY(3), .RESET_PC(RPC)) u_f3 (
    .clk(clk), .rstn(rstn), .enable(enable), .pc_in(pc_in),
    .flush(flush), .done(done3), .pc_out(pco3), .command(cmd3),
    .fault(fault3), .busy(busy3), .imem_en(en3), .imem_addr(addr3),
    .imem_rdata(rd3)
`ifdef FETCH_STATS_EN
    , .stat_fetches(sf3), .stat_stall_cycles(ss3)
`endif
  );

  function automatic logic [31:0] word_at(logic [AW-1:0] a);
    if (a == AW'(16)) return 32'h2001_0005;
    return {17'b0, a} * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic int ml(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // BRAM models: data appears MEM_LATENCY edges after the enable is sampled.
  always @(posedge clk) if (en1) rd1 <= word_at(addr1);

  logic v3a = 1'b0, v3b = 1'b0;
  logic [31:0] d3a = 32'h0, d3b = 32'h0;
  always @(posedge clk) begin
    v3a <= en3;
    d3a <= word_at(addr3);
    v3b <= v3a;
    d3b <= d3a;
    if (v3b) rd3 <= d3b;
  end

  logic          done_a[2], fault_a[2], busy_a[2], en_a[2];
  logic [31:0]   pco_a[2], cmd_a[2];
  logic [AW-1:0] addr_a[2];
  always_comb begin
    done_a[0] = done1;  done_a[1] = done3;
    fault_a[0] = fault1; fault_a[1] = fault3;
    busy_a[0] = busy1;  busy_a[1] = busy3;
    en_a[0] = en1;      en_a[1] = en3;
    pco_a[0] = pco1;    pco_a[1] = pco3;
    cmd_a[0] = cmd1;    cmd_a[1] = cmd3;
    addr_a[0] = addr1;  addr_a[1] = addr3;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cmd;
    logic        flt;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } req_t;

  rsp_t rq[2][$];
  req_t aq[2][$];
  rsp_t me;
  req_t ma;

  logic [31:0] last_pc[2];
  logic [31:0] last_cmd[2];
  int          exp_fetch[2];
  int          exp_stall[2];

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ml%0d: got %h, want %h (cyc %0d)",
               nm, ml(i), act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if (done_a[i]) begin
          if (rq[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done ml%0d: pc %h at cyc %0d",
                     ml(i), pco_a[i], cyc);
          end else begin
            me = rq[i].pop_front();
            chk("pc_out", i, pco_a[i], me.pc);
            chk("command", i, cmd_a[i], me.cmd);
            chk("fault", i, 32'(fault_a[i]), 32'(me.flt));
            chk("done_cycle", i, cyc, me.cyc);
          end
        end
        if (en_a[i]) begin
          if (aq[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_imem_en ml%0d: addr %h at cyc %0d",
                     ml(i), addr_a[i], cyc);
          end else begin
            ma = aq[i].pop_front();
            chk("imem_addr", i, 32'(addr_a[i]), 32'(ma.addr));
            chk("imem_en_cycle", i, cyc, ma.cyc);
          end
        end
      end
    end
  end

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_done", i, 32'(done_a[i]), 32'h0);
      chk("rst_fault", i, 32'(fault_a[i]), 32'h0);
      chk("rst_busy", i, 32'(busy_a[i]), 32'h0);
      chk("rst_imem_en", i, 32'(en_a[i]), 32'h0);
      chk("rst_imem_addr", i, 32'(addr_a[i]), 32'h0);
      chk("rst_command", i, cmd_a[i], 32'h0);
      chk("rst_pc_out", i, pco_a[i], RPC);
      last_pc[i]   = RPC;
      last_cmd[i]  = 32'h0;
      exp_fetch[i] = 0;
      exp_stall[i] = 0;
    end
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetches", 0, sf1, 32'h0);
    chk("rst_stat_fetches", 1, sf3, 32'h0);
    chk("rst_stat_stalls", 0, ss1, 32'h0);
    chk("rst_stat_stalls", 1, ss3, 32'h0);
`endif
  endtask

  // One transaction. j: cycle offset of an extra (ignored) enable, k: cycle
  // offset of a flush (0 = none), f0: flush together with the start enable.
  task automatic issue(logic [31:0] pc, int j, int k, bit f0);
    int  c;
    bit  bad;
    @(posedge clk);
    #1;
    c = cyc;
    pc_in  = pc;
    enable = 1'b1;
    flush  = f0;
    bad = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (f0) begin
      end else if (bad) begin
        rq[i].push_back('{pc, 32'h0, 1'b1, c + 1});
        last_pc[i]  = pc;
        last_cmd[i] = 32'h0;
        exp_stall[i] += 1;
      end else begin
        aq[i].push_back('{pc[AW+1:2], c + 1});
        if (k == 0 || k > ml(i) + 1) begin
          rq[i].push_back('{pc, word_at(pc[AW+1:2]), 1'b0, c + 2 + ml(i)});
          last_pc[i]  = pc;
          last_cmd[i] = word_at(pc[AW+1:2]);
          exp_fetch[i] += 1;
          exp_stall[i] += ml(i) + 2;
        end else begin
          exp_stall[i] += k;
        end
      end
    end
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      #1;
      if (k != 0 && t == k + 1) begin
        for (int i = 0; i < 2; i++)
          chk("busy_after_flush", i, 32'(busy_a[i]), 32'h0);
      end
      enable = (t == j);
      flush  = (t == k);
      pc_in  = $urandom;
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
    flush  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("held_pc_out", i, pco_a[i], last_pc[i]);
      chk("held_command", i, cmd_a[i], last_cmd[i]);
      chk("idle_busy", i, 32'(busy_a[i]), 32'h0);
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetches", 0, sf1, exp_fetch[0]);
    chk("stat_fetches", 1, sf3, exp_fetch[1]);
    chk("stat_stalls", 0, ss1, exp_stall[0]);
    chk("stat_stalls", 1, ss3, exp_stall[1]);
`endif
  endtask

  initial begin
    logic [31:0] pc;
    int sel, k, j, jmax;
    bit f0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    issue(32'h0000_0040, 0, 0, 1'b0);
    issue(32'h0000_0042, 1, 0, 1'b0);
    issue(32'h0002_0000, 0, 0, 1'b0);
    issue(32'h0000_0044, 2, 0, 1'b0);
    issue(32'h0000_0080, 0, 3, 1'b0);
    issue(32'h0000_0084, 1, 2, 1'b0);
    issue(32'h0000_0088, 0, 0, 1'b1);
    issue(32'h0001_FFFC, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      pc  = {15'b0, 15'($urandom), 2'b00};
      if (sel == 7) pc = pc | 32'($urandom_range(1, 3));
      if (sel >= 8)
        pc = ($urandom & 32'hFFFF_FFFC) | (32'h1 << $urandom_range(17, 31));
      f0 = ($urandom_range(0, 9) == 0);
      k  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
      if (f0) k = 0;
      if (f0) jmax = 0;
      else if (sel >= 7) jmax = 1;
      else if (k != 0 && k < 3) jmax = k;
      else jmax = 3;
      j = $urandom_range(0, jmax);
      issue(pc, j, k, f0);
    end

    @(posedge clk);
    #1;
    pc_in  = 32'h0000_0100;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) aq[i].push_back('{AW'(64), cyc + 1});
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete();
      aq[i].delete();
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_busy", i, 32'(busy_a[i]), 32'h0);
      chk("post_rst_pc_out", i, pco_a[i], RPC);
      chk("post_rst_command", i, cmd_a[i], 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
